// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, condition-code encoding and entry layout for the ALU result buffer
//
// Purpose: constants and types common to the result buffer and its users.
//   WIDTH    : ALU result width
//   TAGW     : destination register index width
//   cc_t     : architectural condition codes {z, n, p}
//   CC_RESET : condition codes after reset (Z set)
//   Entry packing order, MSB to LSB: {data, ofl, z, n, p, dst, setcc}
package alu_pkg;

   localparam int WIDTH = 16;
   localparam int TAGW  = 3;

   typedef struct packed {
      logic z;
      logic n;
      logic p;
   } cc_t;

   localparam cc_t CC_RESET = '{z: 1'b1, n: 1'b0, p: 1'b0};

   // Bits carried alongside data and dst in each entry: ofl, z, n, p, setcc.
   localparam int ENTRY_CTRL_BITS = 5;

   function automatic int entry_width(input int data_w, input int tag_w);
      return data_w + tag_w + ENTRY_CTRL_BITS;
   endfunction

endpackage

// File: rtl/rb_ptr.sv
// rtl/rb_ptr.sv - wrapping pointer register with increment enable
//
// Purpose: modulo-2^W pointer used for the buffer read and write positions.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, pointer returns to 0
//   en_i  : advance the pointer by one on the next edge
//   ptr_o : current pointer value
module rb_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q;

   // Natural binary wrap gives modulo-DEPTH since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= ptr_q + W'(1);
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - in-order result FIFO between ALU and writeback with CC update on retire
//
// Purpose: captures ALU results with flags and destination tag, presents them to
// writeback in order, and updates condition codes / sticky overflow on retirement.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : producer handshake; in_ready = count < DEPTH
//   in_data, in_ofl, in_z/n/p    : ALU result and flags
//   in_dst, in_setcc             : destination tag, update-CC-on-retire flag
//   out_valid/out_ready          : writeback handshake
//   out_data, out_dst, out_ofl   : head entry fields
//   cc_z, cc_n, cc_p             : architectural condition codes
//   ofl_sticky, clr_ofl          : sticky overflow and its clear
//   count                        : occupancy
module alu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int TAGW  = alu_pkg::TAGW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_ofl,
   input  logic                       in_z,
   input  logic                       in_n,
   input  logic                       in_p,
   input  logic [TAGW-1:0]            in_dst,
   input  logic                       in_setcc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [TAGW-1:0]            out_dst,
   output logic                       out_ofl,
   output logic                       cc_z,
   output logic                       cc_n,
   output logic                       cc_p,
   output logic                       ofl_sticky,
   input  logic                       clr_ofl,
   output logic [$clog2(DEPTH):0]     count
);

   import alu_pkg::*;

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int ENTW = entry_width(WIDTH, TAGW);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ENTW-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   cc_t             cc_q;
   logic            sticky_q;

   logic            push;
   logic            pop;
   logic            head_z;
   logic            head_n;
   logic            head_p;
   logic            head_setcc;

   // in_ready comes from registered count only, so a same-cycle pop never opens a full buffer.
   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   rb_ptr #(.W(PW)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .en_i  (push),
      .ptr_o (wr_ptr)
   );

   rb_ptr #(.W(PW)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .en_i  (pop),
      .ptr_o (rd_ptr)
   );

   // Storage is deliberately not reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr] <= {in_data, in_ofl, in_z, in_n, in_p, in_dst, in_setcc};
      end
   end

   assign {out_data, out_ofl, head_z, head_n, head_p, out_dst, head_setcc} = mem_q[rd_ptr];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         cc_q     <= CC_RESET;
         sticky_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (pop && head_setcc) begin
            cc_q <= '{z: head_z, n: head_n, p: head_p};
         end
         // A retiring overflow outranks a simultaneous clear.
         if (pop && out_ofl) begin
            sticky_q <= 1'b1;
         end else if (clr_ofl) begin
            sticky_q <= 1'b0;
         end
      end
   end

   assign count      = count_q;
   assign cc_z       = cc_q.z;
   assign cc_n       = cc_q.n;
   assign cc_p       = cc_q.p;
   assign ofl_sticky = sticky_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_ofl = 1'b0;
   logic        in_z = 1'b0;
   logic        in_n = 1'b0;
   logic        in_p = 1'b0;
   logic [2:0]  in_dst = '0;
   logic        in_setcc = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [2:0]  out_dst;
   logic        out_ofl;
   logic        cc_z, cc_n, cc_p;
   logic        ofl_sticky;
   logic        clr_ofl = 1'b0;
   logic [2:0]  count;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(16), .TAGW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ofl(in_ofl), .in_z(in_z), .in_n(in_n), .in_p(in_p),
      .in_dst(in_dst), .in_setcc(in_setcc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_dst(out_dst), .out_ofl(out_ofl),
      .cc_z(cc_z), .cc_n(cc_n), .cc_p(cc_p),
      .ofl_sticky(ofl_sticky), .clr_ofl(clr_ofl), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        ofl;
      logic        z, n, p;
      logic [2:0]  dst;
      logic        setcc;
   } ent_t;

   ent_t       mq[$];
   logic [2:0] m_cc = 3'b100;
   logic       m_sticky = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue of entries and the retire rules, applied at each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_cc = 3'b100;
         m_sticky = 1'b0;
      end else begin
         bit do_push, do_pop;
         ent_t e;
         do_push = in_valid && (mq.size() < DEPTH);
         do_pop  = out_ready && (mq.size() != 0);
         if (do_pop) begin
            e = mq.pop_front();
            if (e.setcc) m_cc = {e.z, e.n, e.p};
            if (e.ofl) m_sticky = 1'b1;
            else if (clr_ofl) m_sticky = 1'b0;
         end else if (clr_ofl) begin
            m_sticky = 1'b0;
         end
         if (do_push) mq.push_back('{in_data, in_ofl, in_z, in_n, in_p, in_dst, in_setcc});
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("count", 32'(count), 32'(mq.size()));
         check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
         check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            check("out_data", 32'(out_data), 32'(mq[0].data));
            check("out_dst", 32'(out_dst), 32'(mq[0].dst));
            check("out_ofl", 32'(out_ofl), 32'(mq[0].ofl));
         end
         check("cc", 32'({cc_z, cc_n, cc_p}), 32'(m_cc));
         check("ofl_sticky", 32'(ofl_sticky), 32'(m_sticky));
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic o,
                        input logic z, input logic n, input logic p,
                        input logic [2:0] dst, input logic sc);
      in_valid = v; in_data = d; in_ofl = o;
      in_z = z; in_n = n; in_p = p; in_dst = dst; in_setcc = sc;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_cc", 32'({cc_z, cc_n, cc_p}), 32'b100);
      check("rst_sticky", 32'(ofl_sticky), 32'd0);
      rst = 1'b0;

      // Single entry: negative result, retire updates CC to 010.
      out_ready = 1'b1;
      drive(1, 16'h8000, 0, 0, 1, 0, 3'd3, 1);
      cyc();
      drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", 32'(out_data), 32'h8000);
      check("t1_dst", 32'(out_dst), 32'd3);
      cyc();
      check("t1_cc", 32'({cc_z, cc_n, cc_p}), 32'b010);
      check("t1_empty", 32'(out_valid), 32'd0);

      // Fill to DEPTH with writeback stalled, then overflow attempt.
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 16'h00A0 + 16'(i), 0, 0, 0, 1, 3'(i), 0);
         cyc();
      end
      check("t2_count_full", 32'(count), 32'd4);
      check("t2_in_ready", 32'(in_ready), 32'd0);
      drive(1, 16'hDEAD, 0, 0, 0, 0, 3'd7, 1);
      cyc();
      check("t2_push_ignored", 32'(count), 32'd4);
      check("t2_head_kept", 32'(out_data), 32'h00A0);
      // Full with simultaneous push and pop: pop only.
      out_ready = 1'b1;
      cyc();
      drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 0);
      check("t3_count", 32'(count), 32'd3);
      check("t3_head", 32'(out_data), 32'h00A1);
      repeat (4) cyc();
      check("t3_drained", 32'(count), 32'd0);
      check("t3_cc_held", 32'({cc_z, cc_n, cc_p}), 32'b010);

      // Streaming: 10 back-to-back entries, pointers wrap.
      for (int i = 0; i < 10; i++) begin
         drive(1, 16'h0100 + 16'(i), 0, (i % 3) == 0, (i % 3) == 1, (i % 3) == 2,
               3'(i), 1'(i % 2));
         cyc();
      end
      drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 0);
      check("t4_count_steady", 32'(count), 32'd1);
      cyc();
      // Last setcc entry was i=9 -> i%3==0 -> z.
      check("t4_cc", 32'({cc_z, cc_n, cc_p}), 32'b100);

      // Set CC to 001, then retire ofl entry (setcc=0, z=1) with clr_ofl asserted.
      drive(1, 16'h0005, 0, 0, 0, 1, 3'd1, 1);
      cyc();
      drive(1, 16'h0000, 1, 1, 0, 0, 3'd2, 0);
      cyc();
      drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 0);
      clr_ofl = 1'b1;
      check("t5_head_ofl", 32'(out_ofl), 32'd1);
      cyc();
      clr_ofl = 1'b0;
      check("t5_set_wins", 32'(ofl_sticky), 32'd1);
      check("t5_cc_unchanged", 32'({cc_z, cc_n, cc_p}), 32'b001);
      clr_ofl = 1'b1;
      cyc();
      clr_ofl = 1'b0;
      check("t5_cleared", 32'(ofl_sticky), 32'd0);

      // Asynchronous reset with two entries pending.
      out_ready = 1'b0;
      drive(1, 16'h1234, 0, 0, 1, 0, 3'd4, 1);
      cyc();
      drive(1, 16'h5678, 0, 0, 1, 0, 3'd5, 1);
      cyc();
      drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 0);
      check("t6_count2", 32'(count), 32'd2);
      out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("t6_rst_count", 32'(count), 32'd0);
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_cc", 32'({cc_z, cc_n, cc_p}), 32'b100);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      repeat (2) cyc();
      check("t6_after", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
